// File: rtl/aes_arb_pkg.sv
// Shared definitions for the two-requester AES core arbiter:
// FSM encoding, key-mode codes, key-compare mask and tag FIFO depth.
package aes_arb_pkg;

    localparam int unsigned TAG_DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DRAIN     = 3'd1,
        KEY_START = 3'd2,
        KEY_WAIT  = 3'd3,
        STREAM    = 3'd4
    } state_t;

    localparam logic [1:0] MODE_128  = 2'b00;
    localparam logic [1:0] MODE_192  = 2'b01;
    localparam logic [1:0] MODE_256  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // Keys are MSB-aligned, so shorter modes ignore the low-order bits.
    function automatic logic [255:0] mode_mask(input logic [1:0] mode);
        logic [255:0] mask;
        case (mode)
            MODE_128: mask = {{128{1'b1}}, {128{1'b0}}};
            MODE_192: mask = {{192{1'b1}}, {64{1'b0}}};
            default:  mask = '1;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/aes_arb_tag_fifo.sv
// One-bit tag FIFO recording which requester owns each block in flight.
// Simultaneous push and pop is accepted even when full.
module aes_arb_tag_fifo
    import aes_arb_pkg::*;
#(
    parameter int unsigned DEPTH = TAG_DEPTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic pop_data,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aes_arb.sv
// Round-robin arbiter sharing one pipelined AES core between two requesters,
// reloading the key only when the winning request's context differs.
module aes_arb
    import aes_arb_pkg::*;
#(
    parameter int unsigned TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_req0_valid,
    input  logic [127:0] i_req0_data,
    input  logic [255:0] i_req0_key,
    input  logic [1:0]   i_req0_key_mode,
    input  logic         i_req0_ende,
    output logic         o_req0_ready,
    input  logic         i_req1_valid,
    input  logic [127:0] i_req1_data,
    input  logic [255:0] i_req1_key,
    input  logic [1:0]   i_req1_key_mode,
    input  logic         i_req1_ende,
    output logic         o_req1_ready,
    output logic         o_aes_start,
    output logic         o_aes_enable,
    output logic         o_aes_ende,
    output logic [255:0] o_aes_key,
    output logic [1:0]   o_aes_key_mode,
    output logic         o_aes_data_valid,
    output logic [127:0] o_aes_data,
    input  logic         i_aes_ready,
    input  logic         i_aes_key_ready,
    input  logic         i_aes_data_valid,
    input  logic [127:0] i_aes_data,
    output logic         o_rsp_valid,
    output logic         o_rsp_id,
    output logic [127:0] o_rsp_data,
    output logic         o_err
);

    state_t       state;
    state_t       state_nxt;
    logic         ptr;
    logic         ld_valid;
    logic [255:0] ld_key;
    logic [1:0]   ld_mode;
    logic         ld_ende;
    logic         kw_armed;

    logic         win_valid;
    logic         win_id;
    logic [127:0] win_data;
    logic [255:0] win_key;
    logic [1:0]   win_mode;
    logic         win_ende;
    logic [255:0] win_mkey;
    logic         rsvd;
    logic         match;

    logic         issue;
    logic         consume;
    logic         start;

    logic         fifo_head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         rsp_hit;

    always_comb begin
        win_valid = i_req0_valid || i_req1_valid;
        win_id    = (i_req0_valid && i_req1_valid) ? ptr : i_req1_valid;
        win_data  = win_id ? i_req1_data     : i_req0_data;
        win_key   = win_id ? i_req1_key      : i_req0_key;
        win_mode  = win_id ? i_req1_key_mode : i_req0_key_mode;
        win_ende  = win_id ? i_req1_ende     : i_req0_ende;
    end

    assign win_mkey = win_key & mode_mask(win_mode);
    assign rsvd     = (win_mode == MODE_RSVD);
    assign match    = ld_valid && (win_mkey == ld_key) && (win_mode == ld_mode)
                      && (win_ende == ld_ende);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        consume   = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    if (rsvd)       consume   = 1'b1;
                    else if (match) state_nxt = STREAM;
                    else            state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !i_aes_data_valid) state_nxt = KEY_START;
            end
            KEY_START: begin
                start     = 1'b1;
                state_nxt = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (kw_armed && i_aes_key_ready) state_nxt = STREAM;
            end
            STREAM: begin
                if (!win_valid) begin
                    state_nxt = IDLE;
                end else if (rsvd) begin
                    consume = 1'b1;
                end else if (match) begin
                    if (i_aes_ready && !fifo_full) begin
                        issue   = 1'b1;
                        consume = 1'b1;
                    end
                end else begin
                    state_nxt = DRAIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Handshake strobes stay quiet while reset is held.
        if (reset) begin
            issue   = 1'b0;
            consume = 1'b0;
            start   = 1'b0;
        end
    end

    assign o_req0_ready     = consume && !win_id;
    assign o_req1_ready     = consume && win_id;
    assign o_aes_start      = start;
    assign o_aes_enable     = !reset;
    assign o_aes_data_valid = issue;
    assign o_aes_data       = issue ? win_data : '0;
    assign o_aes_key        = reset ? '0   : (start ? win_mkey : ld_key);
    assign o_aes_key_mode   = reset ? '0   : (start ? win_mode : ld_mode);
    assign o_aes_ende       = reset ? 1'b0 : (start ? win_ende : ld_ende);

    assign rsp_hit = i_aes_data_valid && !fifo_empty;

    aes_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (issue),
        .push_data (win_id),
        .pop       (i_aes_data_valid),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            ld_valid    <= 1'b0;
            ld_key      <= '0;
            ld_mode     <= '0;
            ld_ende     <= 1'b0;
            kw_armed    <= 1'b0;
            o_err       <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= 1'b0;
            o_rsp_data  <= '0;
        end else begin
            state    <= state_nxt;
            kw_armed <= (state == KEY_WAIT);
            if (consume) ptr <= ~win_id;
            if (start) begin
                ld_valid <= 1'b1;
                ld_key   <= win_mkey;
                ld_mode  <= win_mode;
                ld_ende  <= win_ende;
            end
            if ((consume && rsvd) || (i_aes_data_valid && fifo_empty)) o_err <= 1'b1;
            o_rsp_valid <= rsp_hit;
            if (rsp_hit) begin
                o_rsp_id   <= fifo_head;
                o_rsp_data <= i_aes_data;
            end
        end
    end

endmodule

// File: doc/aes_arb.md
AES_ARB -- requirements
Module: aes_arb

Interface
REQ-001 Parameter TAG_DEPTH, default 16: maximum blocks in flight inside the core (power of two, 2..64).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 i_req0_valid / i_req1_valid  in  1 each  requester n presents a block.
REQ-005 o_req0_ready / o_req1_ready  out  1 each  block of requester n consumed this cycle.
REQ-006 i_reqN_data  in  128  block; i_reqN_key  in  256  key, MSB-aligned; i_reqN_key_mode  in  2  (00=128, 01=192, 10=256, 11=reserved); i_reqN_ende  in  1  (1=decrypt).
REQ-007 o_aes_start, o_aes_enable, o_aes_ende, o_aes_data_valid  out  1; o_aes_key  out  256; o_aes_key_mode  out  2; o_aes_data  out  128  drive the core.
REQ-008 i_aes_ready, i_aes_key_ready, i_aes_data_valid  in  1; i_aes_data  in  128  from the core.
REQ-009 o_rsp_valid  out  1; o_rsp_id  out  1; o_rsp_data  out  128  result and owning requester.
REQ-010 o_err  out  1  sticky error flag.

Function
REQ-011 FSM states IDLE, DRAIN, KEY_START, KEY_WAIT, STREAM.
REQ-012 Round-robin arbitration between valid requesters; the pointer advances past the winner after each accepted block; with both valid at reset, requester 0 wins first.
REQ-013 Loaded context = {key masked by mode, mode, ende, loaded flag}; mask: mode 00 compares key[255:128], 01 compares key[255:64], 10 compares all 256 bits.
REQ-014 IDLE/STREAM: a winner whose context matches the loaded context is issued in STREAM; on mismatch, go to DRAIN.
REQ-015 DRAIN: issue nothing; leave for KEY_START when the tag FIFO is empty and no core result is pending.
REQ-016 KEY_START: o_aes_start high for exactly one cycle, with o_aes_key/o_aes_key_mode/o_aes_ende from the winner; the loaded context is updated; go to KEY_WAIT.
REQ-017 KEY_WAIT: i_aes_key_ready is ignored in the first cycle; move to STREAM on the first later cycle it is high.
REQ-018 Issue in STREAM when winner valid && context match && i_aes_ready && tag FIFO not full.
REQ-019 On issue: o_aes_data_valid=1, o_aes_data=winner data, o_reqN_ready=1 for that requester only, and the requester id is pushed to the tag FIFO.
REQ-020 Sustained throughput is one block per cycle for back-to-back matching requests.
REQ-021 On i_aes_data_valid: pop the tag FIFO; on the next cycle drive o_rsp_valid=1, o_rsp_data=i_aes_data, o_rsp_id=popped id. Latency is one cycle. There is no response backpressure.
REQ-022 Push and pop in the same cycle on a full FIFO: legal, occupancy unchanged.
REQ-023 i_aes_data_valid with the FIFO empty: o_err set; no response is emitted.
REQ-024 key_mode 11: the block is consumed (ready pulse) without issue; o_err set; the FSM state is unchanged.
REQ-025 STREAM with no valid requester: return to IDLE; the loaded context is retained.
REQ-026 o_aes_enable is constant 1 outside reset.

Reset
REQ-027 Reset state: FSM IDLE; loaded flag 0; tag FIFO empty; RR pointer to requester 0; o_err 0.
REQ-028 Reset output values: all o_reqN_ready, o_aes_start, o_aes_data_valid, o_rsp_valid = 0; all data/key/mode/ende/id outputs = 0; o_aes_enable = 0.
REQ-029 Reset mid-operation discards in-flight tags; the first request after reset always triggers a key load.

Structure
REQ-030 Shared package aes_arb_pkg holds: FSM state enum; key-mode constants; the mode-mask function; TAG_DEPTH default.
REQ-031 One sub-module, aes_arb_tag_fifo: synchronous 1-bit-wide FIFO, depth TAG_DEPTH, with full/empty outputs.

Verification
REQ-032 Req0: key 000102..1617 (mode 01, ende 1), data dda97ca4864cdfe06eaf70a0ec0d7191 -> exactly one o_aes_start, then o_rsp_data 00112233445566778899aabbccddeeff with id 0.
REQ-033 Req0 sends 4 blocks back-to-back with the same key -> one key load, 4 consecutive o_aes_data_valid cycles, 4 responses in order with id 0.
REQ-034 Req0 and req1 both valid with different keys -> req0 issued, DRAIN until empty, second o_aes_start, req1 issued; responses ids 0 then 1 with correct data.
REQ-035 Both requesters use the same key, 8 blocks each -> strict alternation 0,1,0,1…; a single key load.
REQ-036 i_aes_ready held low while TAG_DEPTH blocks are in flight -> no issue beyond 16; spurious i_aes_data_valid after drain -> o_err=1.
REQ-037 Reset asserted in KEY_WAIT, then the same request resent -> new o_aes_start issued and the correct result returned.
